// File: rtl/best_match_select_pkg.sv
// Shared constants and state encoding for the best-match selector.
package best_match_select_pkg;
    localparam int NUM_PE    = 16;
    localparam int DIST_W    = 8;
    localparam int BATCH_CNT = 16;
    localparam int X_BIAS    = 8;
    localparam int MV_W      = 4;

    typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/best_match_select_min_compare.sv
// Strict-less compare of a candidate against the running best, with a forced take
// for the first candidate after a clear.
module min_compare #(
    parameter int DIST_W = 8,
    parameter int MV_W   = 4
) (
    input  logic              force_take,
    input  logic [DIST_W-1:0] cur_dist,
    input  logic [MV_W-1:0]   cur_x,
    input  logic [MV_W-1:0]   cur_y,
    input  logic [DIST_W-1:0] cand_dist,
    input  logic [MV_W-1:0]   cand_x,
    input  logic [MV_W-1:0]   cand_y,
    output logic              take,
    output logic [DIST_W-1:0] sel_dist,
    output logic [MV_W-1:0]   sel_x,
    output logic [MV_W-1:0]   sel_y
);
    // Strict less keeps the earlier candidate on ties.
    assign take     = force_take || (cand_dist < cur_dist);
    assign sel_dist = take ? cand_dist : cur_dist;
    assign sel_x    = take ? cand_x    : cur_x;
    assign sel_y    = take ? cand_y    : cur_y;
endmodule

// File: rtl/best_match_select.sv
// Captures a batch of PE distances and scans them one per cycle, tracking the
// minimum distance and its motion vector across up to BATCH_CNT batches.
module best_match_select #(
    parameter int NUM_PE = best_match_select_pkg::NUM_PE,
    parameter int DIST_W = best_match_select_pkg::DIST_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     CompStart,
    input  logic [NUM_PE-1:0]        PEready,
    input  logic [NUM_PE*DIST_W-1:0] Distance,
    input  logic [3:0]               VectorY,
    output logic [DIST_W-1:0]        BestDist,
    output logic [3:0]               MotionX,
    output logic [3:0]               MotionY,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Overrun
);
    import best_match_select_pkg::*;

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_t                         state, state_n;
    logic [NUM_PE-1:0][DIST_W-1:0]  lanes;
    logic [IDX_W-1:0]               idx;
    logic [4:0]                     bcnt;
    logic                           first;
    logic [3:0]                     ycap;

    logic                           capture, scan_en, last;
    logic                           take;
    logic [DIST_W-1:0]              sel_dist;
    logic [3:0]                     sel_x, sel_y, cand_x;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // CompStart low overrides everything, discarding any partial scan.
    always_comb begin
        state_n = state;
        if (!CompStart) state_n = IDLE;
        else begin
            case (state)
                IDLE:    if (capture) state_n = SCAN;
                SCAN:    if (last)    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        capture = CompStart && (state == IDLE) && (|PEready) && (bcnt != 5'(BATCH_CNT));
        scan_en = CompStart && (state == SCAN);
        last    = scan_en && (idx == IDX_W'(NUM_PE - 1));
    end

    assign cand_x = 4'(idx) - 4'(X_BIAS);

    min_compare #(.DIST_W(DIST_W), .MV_W(4)) u_cmp (
        .force_take (first),
        .cur_dist   (BestDist),
        .cur_x      (MotionX),
        .cur_y      (MotionY),
        .cand_dist  (lanes[idx]),
        .cand_x     (cand_x),
        .cand_y     (ycap),
        .take       (take),
        .sel_dist   (sel_dist),
        .sel_x      (sel_x),
        .sel_y      (sel_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= '0;
            bcnt     <= '0;
            first    <= 1'b1;
            BestDist <= '1;
            MotionX  <= '0;
            MotionY  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            Busy <= (state_n == SCAN);
            Done <= last && (bcnt == 5'(BATCH_CNT - 1));
            if (!CompStart) begin
                idx     <= '0;
                bcnt    <= '0;
                first   <= 1'b1;
                Overrun <= 1'b0;
            end else begin
                if (capture) begin
                    lanes <= Distance;
                    ycap  <= VectorY;
                    idx   <= '0;
                end
                if ((state == SCAN) && (|PEready)) Overrun <= 1'b1;
                if (scan_en) begin
                    idx <= last ? '0 : idx + 1'b1;
                    if (take) begin
                        BestDist <= sel_dist;
                        MotionX  <= sel_x;
                        MotionY  <= sel_y;
                        first    <= 1'b0;
                    end
                    if (last) bcnt <= bcnt + 5'd1;
                end
            end
        end
    end
endmodule

// File: doc/best_match_select.md
BEST_MATCH_SELECT -- requirements
Module: best_match_select

Interface
REQ-001 Parameter NUM_PE, default 16: number of processing elements per batch, one per horizontal search offset.
REQ-002 Parameter DIST_W, default 8: width of each PE distance.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 CompStart  input  1  search active; low clears accumulated search state.
REQ-006 PEready  input  NUM_PE  per-PE distance-valid strobes; all bits assert together for one cycle per batch.
REQ-007 Distance  input  NUM_PE*DIST_W  packed PE distances; PE i at bits [DIST_W*i+DIST_W-1 : DIST_W*i].
REQ-008 VectorY  input  4  two's-complement vertical offset of the current batch; sampled together with Distance.
REQ-009 BestDist  output  DIST_W  minimum distance found so far.
REQ-010 MotionX  output  4  two's-complement horizontal offset of BestDist, equal to PE index minus 8.
REQ-011 MotionY  output  4  two's-complement vertical offset of BestDist.
REQ-012 Busy  output  1  high while a captured batch is being scanned.
REQ-013 Done  output  1  one-cycle pulse when the 16th batch has been fully scanned.
REQ-014 Overrun  output  1  sticky flag: a batch arrived while Busy.

Function
REQ-015 Capture edge: at a rising edge where CompStart=1, state=IDLE and |PEready=1, the block registers all Distance lanes and VectorY, sets scan index to 0, and enters SCAN.
REQ-016 In SCAN, each edge compares lane[index] with BestDist and increments index; after index NUM_PE-1 the block returns to IDLE, so the scan takes exactly NUM_PE edges after capture.
REQ-017 The first candidate after a clear is always accepted; afterwards a candidate replaces the best only if strictly less, so ties keep the earlier candidate (lower batch, then lower PE index).
REQ-018 On acceptance, BestDist, MotionX (index-8, 4-bit wrap) and MotionY (captured VectorY) update at the same edge.
REQ-019 Batch counter (5 bits) increments at the final SCAN edge; when it reaches 16, Done is high for the single cycle after that edge and further batches are ignored until a clear.
REQ-020 Busy is high exactly during the NUM_PE cycles following the capture edge.
REQ-021 Batch while Busy or after the 16th batch: the batch is ignored, and Overrun is set only if it arrived while Busy.
REQ-022 CompStart=0 at an edge: state returns to IDLE, the batch counter and accept-first flag clear, Overrun clears, and BestDist/MotionX/MotionY hold their last values; this applies even mid-scan (the partial scan is discarded).
REQ-023 Comparisons are unsigned DIST_W-bit comparisons; no saturation or accumulation is performed.

Reset
REQ-024 reset=1 at an edge: state IDLE, index 0, batch counter 0, accept-first flag set, BestDist all ones, MotionX=0, MotionY=0, Busy=0, Done=0, Overrun=0.
REQ-025 reset takes priority over CompStart and PEready in the same cycle.

Structure
REQ-026 A shared package holds NUM_PE, DIST_W, the batch count constant 16, the X offset bias 8, and the state enumeration IDLE/SCAN.
REQ-027 One sub-module, min_compare, holds the combinational strict-less compare and select of (distance, X, Y), and is instantiated once.
REQ-028 Captured lanes are held in a register array; outputs are registered with no combinational path from inputs.

Verification
REQ-029 Single batch: lanes 0..15 = 50,40,30,30,90,... and VectorY=-3 -> after 16 edges BestDist=30, MotionX=-6 (lane 2), MotionY=-3, Busy low.
REQ-030 16 batches spaced 256 cycles apart, global minimum 5 at batch 9, lane 15, VectorY=2 -> Done pulses once, one cycle after the last scan edge; BestDist=5, MotionX=7, MotionY=2.
REQ-031 All lanes = 255 in every batch -> BestDist=255, MotionX=-8, MotionY equal to the first batch's VectorY.
REQ-032 Second PEready 5 cycles after a capture -> the second batch is ignored, Overrun=1, results reflect the first batch only.
REQ-033 CompStart dropped at scan index 7 -> Busy low on the next cycle, counter 0, a new batch with minimum 200 is accepted as best although the held BestDist is lower.
REQ-034 reset asserted mid-scan together with PEready -> all outputs take their REQ-024 values on the next cycle, and no capture occurs.
